alu_32: RTL and testbench



---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_if.sv | 13 +
 rtl/cla32.sv | 53 +++++
 rtl/alu_32.sv | 52 +++++
 tb/tb_alu_32.sv | 121 ++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding and widths for the 32-bit ALU execution stage.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int RES_W  = 64;

    typedef enum logic [3:0] {
        OP_NOT_A = 4'b0000,
        OP_NOT_B = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_XNOR  = 4'b0101,
        OP_ADD   = 4'b0110,
        OP_SUB   = 4'b0111
    } op_e;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode/result bundle between the issue logic and the ALU stage.
interface alu_if;
    import alu_pkg::*;

    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        op;
    logic [RES_W-1:0]  result;

    modport master (output a, b, op, input result);
    modport slave  (input a, b, op, output result);

endinterface

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: eight 4-bit CLA groups chained by group generate/propagate.
module cla32
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    localparam int NGRP = DATA_W / 4;

    logic [NGRP-1:0] grp_g;
    logic [NGRP-1:0] grp_p;
    logic [NGRP-1:0] grp_cin;

    genvar gi;
    generate
        for (gi = 0; gi < NGRP; gi++) begin : grp
            logic [3:0] g, p, c;
            logic       c0;

            assign g  = a[4*gi +: 4] & b[4*gi +: 4];
            assign p  = a[4*gi +: 4] ^ b[4*gi +: 4];
            assign c0 = grp_cin[gi];

            // In-group carries are flattened so each depends only on g/p and the group carry-in.
            assign c[0] = c0;
            assign c[1] = g[0] | (p[0] & c0);
            assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
            assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                        | (p[2] & p[1] & p[0] & c0);

            assign sum[4*gi +: 4] = p ^ c;

            assign grp_g[gi] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                             | (p[3] & p[2] & p[1] & g[0]);
            assign grp_p[gi] = &p;
        end
    endgenerate

    always_comb begin
        logic c;
        c = cin;
        for (int i = 0; i < NGRP; i++) begin
            grp_cin[i] = c;
            c = grp_g[i] | (grp_p[i] & c);
        end
        cout = c;
    end

endmodule

// File: rtl/alu_32.sv
// Registered ALU stage: logic unit, shared add/sub adder, opcode mux and 64-bit result register.
module alu_32
    import alu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    logic              is_sub;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W-1:0] sum;
    logic              cout;
    logic [DATA_W:0]   sum33;
    logic [RES_W-1:0]  next_result;

    // SUB reuses the adder as a + ~b + 1.
    assign is_sub = (bus.op == OP_SUB);
    assign b_eff  = is_sub ? ~bus.b : bus.b;

    cla32 u_cla (
        .a    (bus.a),
        .b    (b_eff),
        .cin  (is_sub),
        .sum  (sum),
        .cout (cout)
    );

    // Bit 32 of the sign-extended 33-bit sum; a 33-bit result cannot overflow.
    assign sum33 = {bus.a[DATA_W-1] ^ b_eff[DATA_W-1] ^ cout, sum};

    always_comb begin
        next_result = '0;
        case (op_e'(bus.op))
            OP_NOT_A: next_result = {32'h0, ~bus.a};
            OP_NOT_B: next_result = {32'h0, ~bus.b};
            OP_AND:   next_result = {32'h0, bus.a & bus.b};
            OP_OR:    next_result = {32'h0, bus.a | bus.b};
            OP_XOR:   next_result = {32'h0, bus.a ^ bus.b};
            OP_XNOR:  next_result = {32'h0, ~(bus.a ^ bus.b)};
            OP_ADD,
            OP_SUB:   next_result = {{(RES_W-DATA_W-1){sum33[DATA_W]}}, sum33};
            default:  next_result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.result <= '0;
        else     bus.result <= next_result;
    end

endmodule

// File: tb/tb_alu_32.sv
// Directed-vector bench for alu_32 with a cycle-by-cycle reference model check.
module tb_alu_32;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [63:0] exp_q;

    alu_if bus ();

    alu_32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        case (op)
            4'd0: return {32'h0, ~a};
            4'd1: return {32'h0, ~b};
            4'd2: return {32'h0, a & b};
            4'd3: return {32'h0, a | b};
            4'd4: return {32'h0, a ^ b};
            4'd5: return {32'h0, ~(a ^ b)};
            4'd6: return sa + sb;
            4'd7: return sa - sb;
            default: return 64'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected register contents, tracked alongside the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) exp_q <= 64'h0;
        else     exp_q <= model(bus.op, bus.a, bus.b);
    end

    always @(negedge clk) begin
        check("cycle", bus.result, exp_q);
    end

    task automatic vec(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp);
        @(negedge clk);
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
        check({"model_", name}, model(op, a, b), exp);
        @(posedge clk);
        #1;
        check(name, bus.result, exp);
    endtask

    initial begin
        rst    = 1'b1;
        bus.op = 4'd6;
        bus.a  = 32'h1234_5678;
        bus.b  = 32'h1111_1111;
        #1;
        check("reset_async", bus.result, 64'h0);
        repeat (2) @(negedge clk);
        check("reset_held", bus.result, 64'h0);
        rst = 1'b0;

        vec("not_a",   4'b0000, 32'h0000_FFFF, 32'h1234_5678, 64'h0000_0000_FFFF_0000);
        vec("not_b",   4'b0001, 32'hDEAD_BEEF, 32'h00FF_FF00, 64'h0000_0000_FF00_00FF);
        vec("and",     4'b0010, 32'h0A0B_1100, 32'h1010_AB00, 64'h0000_0000_0000_0100);
        vec("or",      4'b0011, 32'h0A0B_1100, 32'h1010_AB00, 64'h0000_0000_1A1B_BB00);
        vec("xor",     4'b0100, 32'h0A0B_1100, 32'h1010_AB00, 64'h0000_0000_1A1B_BA00);
        vec("xnor",    4'b0101, 32'h0A0B_1100, 32'h1010_AB00, 64'h0000_0000_E5E4_45FF);
        vec("sub",     4'b0111, 32'h0FFF_0000, 32'h000F_FFFF, 64'h0000_0000_0FEF_0001);
        vec("add",     4'b0110, 32'h0FFF_0000, 32'h000F_FFFF, 64'h0000_0000_100E_FFFF);
        vec("add_pos", 4'b0110, 32'h7FFF_FFFF, 32'h0000_0001, 64'h0000_0000_8000_0000);
        vec("sub_neg", 4'b0111, 32'h0000_0000, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);
        vec("add_min", 4'b0110, 32'h8000_0000, 32'h8000_0000, 64'hFFFF_FFFF_0000_0000);
        vec("sub_mix", 4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 64'h0000_0000_FFFF_FFFF);
        vec("sub_mn",  4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 64'hFFFF_FFFF_0000_0001);
        vec("rsv_a",   4'b1010, 32'hFFFF_FFFF, 32'h1234_5678, 64'h0);
        vec("rsv_f",   4'b1111, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 64'h0);

        // Mid-cycle reset with a nonzero result pending.
        vec("pre_rst", 4'b0110, 32'h7FFF_FFFF, 32'h0000_0001, 64'h0000_0000_8000_0000);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid", bus.result, 64'h0);
        @(posedge clk);
        #1;
        check("rst_hold", bus.result, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        vec("post_rst", 4'b0000, 32'h0000_FFFF, 32'h0, 64'h0000_0000_FFFF_0000);

        // Back-to-back random traffic, checked by the per-cycle compare.
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            bus.op = 4'($urandom_range(0, 15));
            bus.a  = $urandom;
            bus.b  = $urandom;
        end
        @(negedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
